// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo
// Packet-aware output buffer, one instance per destination channel. Each
// entry holds a data byte plus a start-of-packet tag. The read side tracks the
// remaining byte count taken from the packet header, so it can flag the first
// (header) and last (parity) byte of every packet.
//
// Ports:
//   clock        rising-edge clock
//   resetn       asynchronous active-low reset
//   soft_reset   synchronous flush, active-high
//   write_enb    write request
//   lfd_state    data_in is a packet header (SOP tag)
//   data_in      write data
//   read_enb     read request
//   data_out     registered read data, valid when rd_valid
//   rd_valid     data_out updated this cycle
//   rd_sop       data_out is a header (aligned with rd_valid)
//   rd_eop       data_out is the packet's last byte (aligned with rd_valid)
//   empty        no stored entries
//   full         DEPTH entries stored
//   almost_full  fill_level >= AF_THRESH
//   fill_level   stored entry count, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     rd_sop,
  output logic                     rd_eop,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = DATA_W - 1;
  localparam int LW = DATA_W - 2;

  localparam logic [PW-1:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [RW-1:0] REM_ONE   = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] REM_ZERO  = {RW{1'b0}};
  localparam logic [PW-1:0] AF_LEVEL  = PW'(AF_THRESH);

  // Entry layout: {sop_tag, data}
  logic [DATA_W:0]   mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [RW-1:0]     rem_r;

  logic              empty_s;
  logic              full_s;
  logic [PW-1:0]     fill_s;
  logic              wr_accept_s;
  logic              rd_accept_s;
  logic [DATA_W:0]   rd_entry_s;
  logic              rd_hdr_s;
  logic [LW-1:0]     rd_len_s;
  logic [RW-1:0]     rem_nxt_s;
  logic              eop_nxt_s;

  // Pointer-derived status; the extra MSB distinguishes full from empty.
  always_comb begin
    fill_s      = wr_ptr_r - rd_ptr_r;
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    wr_accept_s = write_enb && !full_s;
    rd_accept_s = read_enb && !empty_s;
  end

  assign empty       = empty_s;
  assign full        = full_s;
  assign fill_level  = fill_s;
  assign almost_full = (fill_s >= AF_LEVEL);

  // Packet tracking: next remaining count and last-byte flag for the entry
  // about to be read. A header always reloads, even mid-packet.
  always_comb begin
    rd_entry_s = mem_r[rd_ptr_r[AW-1:0]];
    rd_hdr_s   = rd_entry_s[DATA_W];
    rd_len_s   = rd_entry_s[DATA_W-1:2];
    rem_nxt_s  = rem_r;
    eop_nxt_s  = 1'b0;
    if (rd_hdr_s) begin
      rem_nxt_s = {1'b0, rd_len_s} + REM_ONE;
      eop_nxt_s = 1'b0;
    end else if (rem_r != REM_ZERO) begin
      rem_nxt_s = rem_r - REM_ONE;
      eop_nxt_s = (rem_r == REM_ONE);
    end else begin
      rem_nxt_s = REM_ZERO;
      eop_nxt_s = 1'b0;
    end
  end

  // Storage array; contents are intentionally left untouched by any reset.
  always_ff @(posedge clock) begin
    if (wr_accept_s && !soft_reset) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Pointers, read port, packet tracker and sticky error flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      rem_r     <= REM_ZERO;
      data_out  <= {DATA_W{1'b0}};
      rd_valid  <= 1'b0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      rem_r     <= REM_ZERO;
      data_out  <= {DATA_W{1'b0}};
      rd_valid  <= 1'b0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (write_enb && full_s) begin
        overflow <= 1'b1;
      end
      if (read_enb && empty_s) begin
        underflow <= 1'b1;
      end
      rd_valid <= rd_accept_s;
      if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        data_out <= rd_entry_s[DATA_W-1:0];
        rd_sop   <= rd_hdr_s;
        rd_eop   <= eop_nxt_s;
        rem_r    <= rem_nxt_s;
      end else begin
        rd_sop   <= 1'b0;
        rd_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
module tb_router_pkt_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       rd_sop;
  logic       rd_eop;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] fill_level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .rd_valid(rd_valid),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .empty(empty), .full(full),
    .almost_full(almost_full), .fill_level(fill_level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // One clock with the given request; outputs are sampled 1 time unit later.
  task automatic cyc(input logic we, input logic sop, input logic [7:0] din, input logic re);
    write_enb = we; lfd_state = sop; data_in = din; read_enb = re;
    @(posedge clock); #1;
    write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", almost_full); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", data_out); end
    checks++; if ({rd_valid, rd_sop, rd_eop} !== 3'b000) begin errors++; $display("FAIL reset_rdflags: got %b want 000", {rd_valid, rd_sop, rd_eop}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_packet;
    logic [7:0] pkt [5];
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;
    for (int i = 0; i < 5; i++) cyc(1'b1, (i == 0), pkt[i], 1'b0);
    checks++; if (fill_level !== 5'd5) begin errors++; $display("FAIL pkt_fill: got %0d want 5", fill_level); end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (rd_valid !== 1'b1 || data_out !== pkt[i]) begin errors++; $display("FAIL pkt_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, data_out, pkt[i]); end
      checks++; if (rd_sop !== (i == 0) || rd_eop !== (i == 4)) begin errors++; $display("FAIL pkt_flags[%0d]: got sop=%b eop=%b want sop=%b eop=%b", i, rd_sop, rd_eop, (i == 0), (i == 4)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pkt_empty: got %b want 1", empty); end
  endtask

  task automatic test_full;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 8'hA0 + 8'(i);
      cyc(1'b1, 1'b0, d, 1'b0);
      checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL full_af[%0d]: got %b want %b", i + 1, almost_full, (i + 1 >= 14)); end
    end
    checks++; if (full !== 1'b1 || fill_level !== 5'd16) begin errors++; $display("FAIL full_level: got full=%b fill=%0d want full=1 fill=16", full, fill_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_noovf: got %b want 0", overflow); end
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    checks++; if (overflow !== 1'b1 || fill_level !== 5'd16) begin errors++; $display("FAIL full_ovf: got ovf=%b fill=%0d want ovf=1 fill=16", overflow, fill_level); end
    for (int i = 0; i < 16; i++) begin
      d = 8'hA0 + 8'(i);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (rd_valid !== 1'b1 || data_out !== d || rd_sop !== 1'b0 || rd_eop !== 1'b0) begin errors++; $display("FAIL full_drain[%0d]: got v=%b d=%h sop=%b eop=%b want v=1 d=%h sop=0 eop=0", i, rd_valid, data_out, rd_sop, rd_eop, d); end
    end
    checks++; if (underflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL full_end: got unf=%b empty=%b want unf=0 empty=1", underflow, empty); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [$];
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      d = 8'h40 + 8'(i); q.push_back(d);
      cyc(1'b1, 1'b0, d, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'h50 + 8'(i);
      exp = q.pop_front(); q.push_back(d);
      cyc(1'b1, 1'b0, d, 1'b1);
      checks++; if (rd_valid !== 1'b1 || data_out !== exp || fill_level !== 5'd8) begin errors++; $display("FAIL b2b[%0d]: got v=%b d=%h fill=%0d want v=1 d=%h fill=8", i, rd_valid, data_out, fill_level, exp); end
    end
    for (int i = 0; i < 8; i++) begin
      exp = q.pop_front();
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== exp) begin errors++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, data_out, exp); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_boundary_simul;
    logic [7:0] d;
    soft_reset = 1'b1; cyc(1'b0, 1'b0, 8'h00, 1'b0); soft_reset = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bnd_srst_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      d = 8'h60 + 8'(i);
      cyc(1'b1, 1'b0, d, 1'b0);
    end
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    checks++; if (rd_valid !== 1'b1 || data_out !== 8'h60) begin errors++; $display("FAIL bnd_full_rd: got v=%b d=%h want v=1 d=60", rd_valid, data_out); end
    checks++; if (overflow !== 1'b1 || fill_level !== 5'd15) begin errors++; $display("FAIL bnd_full_wr: got ovf=%b fill=%0d want ovf=1 fill=15", overflow, fill_level); end
    for (int i = 1; i < 16; i++) begin
      d = 8'h60 + 8'(i);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== d) begin errors++; $display("FAIL bnd_drain[%0d]: got %h want %h", i, data_out, d); end
    end
    cyc(1'b1, 1'b0, 8'h77, 1'b1);
    checks++; if (rd_valid !== 1'b0 || data_out !== 8'h6F) begin errors++; $display("FAIL bnd_empty_rd: got v=%b d=%h want v=0 d=6f", rd_valid, data_out); end
    checks++; if (underflow !== 1'b1 || fill_level !== 5'd1) begin errors++; $display("FAIL bnd_empty_wr: got unf=%b fill=%0d want unf=1 fill=1", underflow, fill_level); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (rd_valid !== 1'b1 || data_out !== 8'h77) begin errors++; $display("FAIL bnd_empty_data: got v=%b d=%h want v=1 d=77", rd_valid, data_out); end
  endtask

  task automatic test_len0;
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h00 || rd_sop !== 1'b1 || rd_eop !== 1'b0) begin errors++; $display("FAIL len0_hdr: got d=%h sop=%b eop=%b want d=00 sop=1 eop=0", data_out, rd_sop, rd_eop); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h5A || rd_sop !== 1'b0 || rd_eop !== 1'b1) begin errors++; $display("FAIL len0_par: got d=%h sop=%b eop=%b want d=5a sop=0 eop=1", data_out, rd_sop, rd_eop); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({rd_valid, rd_sop, rd_eop} !== 3'b000) begin errors++; $display("FAIL len0_idle: got %b want 000", {rd_valid, rd_sop, rd_eop}); end
  endtask

  task automatic test_soft_reset;
    cyc(1'b1, 1'b1, 8'h0D, 1'b0);
    cyc(1'b1, 1'b0, 8'h01, 1'b0);
    cyc(1'b1, 1'b0, 8'h02, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (rd_sop !== 1'b1 || data_out !== 8'h0D) begin errors++; $display("FAIL srst_hdr: got sop=%b d=%h want sop=1 d=0d", rd_sop, data_out); end
    soft_reset = 1'b1; cyc(1'b1, 1'b0, 8'h99, 1'b1); soft_reset = 1'b0;
    checks++; if (empty !== 1'b1 || fill_level !== 5'd0) begin errors++; $display("FAIL srst_flush: got empty=%b fill=%0d want empty=1 fill=0", empty, fill_level); end
    checks++; if ({rd_valid, rd_sop, rd_eop, overflow, underflow} !== 5'b00000 || data_out !== 8'h00) begin errors++; $display("FAIL srst_flags: got flags=%b d=%h want 00000 d=00", {rd_valid, rd_sop, rd_eop, overflow, underflow}, data_out); end
    cyc(1'b1, 1'b0, 8'h03, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h03 || rd_sop !== 1'b0 || rd_eop !== 1'b0) begin errors++; $display("FAIL srst_stray: got d=%h sop=%b eop=%b want d=03 sop=0 eop=0", data_out, rd_sop, rd_eop); end
    // Build up state, then pull resetn between clock edges.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'hC1, 1'b0);
    cyc(1'b1, 1'b0, 8'hC2, 1'b1);
    checks++; if (rd_valid !== 1'b1 || underflow !== 1'b1 || fill_level !== 5'd1) begin errors++; $display("FAIL arst_pre: got v=%b unf=%b fill=%0d want v=1 unf=1 fill=1", rd_valid, underflow, fill_level); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || data_out !== 8'h00 || underflow !== 1'b0) begin errors++; $display("FAIL arst_regs: got v=%b d=%h unf=%b want v=0 d=00 unf=0", rd_valid, data_out, underflow); end
    checks++; if (empty !== 1'b1 || fill_level !== 5'd0 || full !== 1'b0) begin errors++; $display("FAIL arst_status: got empty=%b fill=%0d full=%b want 1 0 0", empty, fill_level, full); end
    #3 resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    data_in = 8'h00; read_enb = 1'b0;
    #12;
    test_reset;
    resetn = 1'b1;
    @(posedge clock); #1;
    test_packet;
    test_full;
    test_back_to_back;
    test_boundary_simul;
    test_len0;
    test_soft_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
